// File: rtl/i17916_seq_core.sv
// rtl/i17916_seq_core.sv - serial "1011" pattern plus consecutive-ones run detector with a registered flag
// Optional build macro I17916_PAYLOAD_EN adds a sticky arm bit that inverts the flag after a history match.
module i17916_seq_core #(
   parameter int                RUN_MAX      = 4,
   parameter int                HIST_W       = 8,
   parameter logic [HIST_W-1:0] TRIG_PATTERN = 8'hA5
) (
   input  logic N,
   input  logic CK,
   input  logic reset,
   output logic output_single
);

   typedef enum logic [1:0] {S0, S1, S10, S101} state_t;

   localparam logic [3:0] RUN_MAX_C = 4'(RUN_MAX);

   state_t            state_q, state_d;
   logic [3:0]        run_cnt_q, run_cnt_d;
   logic [HIST_W-1:0] hist_q, hist_d;
   logic              output_single_q, output_single_d;
   logic              hit;
   logic              run_flag;
   logic              det;

   always_comb begin
      state_d = state_q;
      hit     = 1'b0;
      case (state_q)
         S0:      state_d = N ? S1 : S0;
         S1:      state_d = N ? S1 : S10;
         S10:     state_d = N ? S101 : S0;
         S101: begin
            state_d = N ? S1 : S10;
            hit     = N;
         end
         default: state_d = S0;
      endcase
   end

   // Counter saturates at RUN_MAX so the flag holds for as long as N stays high.
   always_comb begin
      run_cnt_d = 4'd0;
      if (N) begin
         run_cnt_d = (run_cnt_q == RUN_MAX_C) ? run_cnt_q : run_cnt_q + 4'd1;
      end
      run_flag = (run_cnt_d == RUN_MAX_C);
      hist_d   = {hist_q[HIST_W-2:0], N};
      det      = hit | run_flag;
   end

`ifdef I17916_PAYLOAD_EN
   logic armed_q, armed_d;

   always_comb begin
      armed_d         = armed_q | (hist_d == TRIG_PATTERN);
      output_single_d = armed_d ? ~det : det;
   end

   always_ff @(posedge CK) begin
      if (!reset) begin
         armed_q <= 1'b0;
      end else begin
         armed_q <= armed_d;
      end
   end
`else
   logic unused_trig;

   always_comb begin
      output_single_d = det;
      unused_trig     = (hist_d == TRIG_PATTERN);
   end
`endif

   always_ff @(posedge CK) begin
      if (!reset) begin
         state_q         <= S0;
         run_cnt_q       <= 4'd0;
         hist_q          <= '0;
         output_single_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         run_cnt_q       <= run_cnt_d;
         hist_q          <= hist_d;
         output_single_q <= output_single_d;
      end
   end

   assign output_single = output_single_q;

endmodule

// File: tb/tb_i17916_seq_core.sv
// tb/tb_i17916_seq_core.sv - scoreboard bench: driver pushes model expectations, monitor pops and compares
module tb_i17916_seq_core;

   localparam int         RUN_MAX = 4;
   localparam int         HIST_W  = 8;
   localparam logic [7:0] TRIG    = 8'hA5;

   logic CK = 1'b0;
   logic reset = 1'b0;
   logic N = 1'b0;
   logic output_single;

   int    n_tests = 0;
   int    n_fail  = 0;
   bit    exp_q[$];
   string name_q[$];
   bit    bits[$];
   bit    armed = 1'b0;

   i17916_seq_core #(
      .RUN_MAX      (RUN_MAX),
      .HIST_W       (HIST_W),
      .TRIG_PATTERN (TRIG)
   ) dut (
      .N             (N),
      .CK            (CK),
      .reset         (reset),
      .output_single (output_single)
   );

   always #5 CK = ~CK;

   // Reference: expected flag derived from the bit history seen since the last reset.
   task automatic drive(input bit rst, input bit n, input string nm);
      bit          e;
      bit          hit;
      bit          run;
      int          sz;
      int          t;
      logic [7:0]  h;
      @(negedge CK);
      reset = rst ? 1'b0 : 1'b1;
      N     = n;
      if (rst) begin
         bits.delete();
         armed = 1'b0;
         e     = 1'b0;
      end else begin
         bits.push_back(n);
         if (bits.size() > 32) void'(bits.pop_front());
         sz  = bits.size();
         hit = (sz >= 4) && bits[sz-4] && !bits[sz-3] && bits[sz-2] && bits[sz-1];
         t   = 0;
         for (int i = sz - 1; i >= 0; i--) begin
            if (!bits[i]) break;
            t++;
         end
         run = (t >= RUN_MAX);
         h   = 8'h00;
         for (int i = 0; i < HIST_W; i++) begin
            if (sz - 1 - i >= 0) h[i] = bits[sz-1-i];
         end
`ifdef I17916_PAYLOAD_EN
         if (h == TRIG) armed = 1'b1;
`endif
         e = armed ? !(hit || run) : (hit || run);
      end
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic drive_seq(input bit [15:0] seq, input int len, input string nm);
      for (int i = len - 1; i >= 0; i--) drive(1'b0, seq[i], nm);
   endtask

   initial begin : monitor
      bit    e;
      string nm;
      forever begin
         @(posedge CK);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_tests++;
            if (output_single !== e) begin
               n_fail++;
               $display("FAIL %s: output_single=%b expected %b", nm, output_single, e);
            end
         end
      end
   end

   initial begin : stimulus
      drive(1'b1, 1'b1, "reset_hold");
      drive(1'b1, 1'b0, "reset_hold");
      drive_seq(16'b1011, 4, "pattern");
      drive(1'b1, 1'b0, "reset");
      drive_seq(16'b1011011, 7, "overlap");
      drive(1'b1, 1'b0, "reset");
      drive_seq(16'b1111110, 7, "run_sat");
      drive(1'b1, 1'b0, "reset");
      drive_seq(16'b101, 3, "mid_reset_pre");
      drive(1'b1, 1'b1, "mid_reset");
      drive_seq(16'b1011, 4, "mid_reset_post");
      drive(1'b1, 1'b0, "reset");
      drive_seq(16'b10100101, 8, "payload");
      drive_seq(16'b0000, 4, "payload_idle");
      drive(1'b1, 1'b0, "payload_reset");
      drive_seq(16'b0000, 4, "post_payload_idle");
      for (int i = 0; i < 2000; i++) begin
         drive($urandom_range(0, 49) == 0, $urandom_range(0, 99) < 60, "random");
      end
      drive(1'b1, 1'b0, "final_reset");
      repeat (3) @(posedge CK);
      #2;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: pending=%0d expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
